// File: rtl/core6502_alu_pkg.sv
// rtl/core6502_alu_pkg.sv - shared ALU operation, decimal-mode types and BCD constants
package core6502_alu_pkg;

  typedef enum logic [2:0] {OP_NONE, OP_SUM, OP_AND, OP_EOR, OP_OR, OP_SR} alu_op_t;
  typedef enum logic [1:0] {BCD_NONE, BCD_ADD, BCD_SUB} bcd_mode_t;

  localparam logic [3:0] BCD_LIMIT = 4'd9;
  localparam logic [3:0] BCD_ADJ   = 4'd6;

  // Op strobes are not guaranteed one-hot; resolve them by fixed priority.
  function automatic alu_op_t op_select(input logic sums, input logic ands,
                                        input logic eors, input logic ors,
                                        input logic srs);
    if (sums)      return OP_SUM;
    else if (ands) return OP_AND;
    else if (eors) return OP_EOR;
    else if (ors)  return OP_OR;
    else if (srs)  return OP_SR;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// rtl/bcd_adjust.sv - per-nibble decimal correction applied on accumulator load
module bcd_adjust
  import core6502_alu_pkg::*;
(
  input  logic [7:0] data,
  input  logic       dc3,
  input  logic       dc7,
  input  bcd_mode_t  mode,
  output logic [7:0] result
);

  logic [3:0] adj_lo;
  logic [3:0] adj_hi;

  assign adj_lo = dc3 ? BCD_ADJ : 4'd0;
  assign adj_hi = dc7 ? BCD_ADJ : 4'd0;

  // Nibbles wrap independently; no carry propagates between them.
  always_comb begin
    result = data;
    case (mode)
      BCD_ADD: result = {data[7:4] + adj_hi, data[3:0] + adj_lo};
      BCD_SUB: result = {data[7:4] - adj_hi, data[3:0] - adj_lo};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - 6502 ALU datapath: AI/BI latches, ADD register, accumulator, decimal flags
module alu_datapath
  import core6502_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             PHI0,
  input  logic             n_RES,
  input  logic [WIDTH-1:0] SB_in,
  input  logic [WIDTH-1:0] DB_in,
  input  logic [WIDTH-1:0] ADL_in,
  input  logic             SB_ADD,
  input  logic             Z_ADD,
  input  logic             DB_ADD,
  input  logic             NDB_ADD,
  input  logic             ADL_ADD,
  input  logic             SUMS,
  input  logic             ANDS,
  input  logic             EORS,
  input  logic             ORS,
  input  logic             SRS,
  input  logic             n_ACIN,
  input  logic             n_DAA,
  input  logic             n_DSA,
  input  logic             ADD_SB06,
  input  logic             ADD_SB7,
  input  logic             ADD_ADL,
  input  logic             SB_AC,
  input  logic             AC_SB,
  input  logic             AC_DB,
  output logic [WIDTH-1:0] SB_out,
  output logic [WIDTH-1:0] SB_oe,
  output logic [WIDTH-1:0] ADL_out,
  output logic             ADL_oe,
  output logic [WIDTH-1:0] DB_out,
  output logic             DB_oe,
  output logic [WIDTH-1:0] ADD,
  output logic [WIDTH-1:0] AC,
  output logic             n_COUT,
  output logic             ACR,
  output logic             AVR
);

  logic [WIDTH-1:0] ai, bi, add_q, ac_q, ac_load;
  logic             acr_q, avr_q, dc3_q, dc7_q;
  bcd_mode_t        mode_q;

  alu_op_t          op;
  logic             cin, hc, daa, dsa, overflow;
  logic [WIDTH:0]   sum;
  logic             dc3_sum, dc7_sum;
  logic [WIDTH-1:0] add_d;
  logic             acr_d, avr_d;

  assign op  = op_select(SUMS, ANDS, EORS, ORS, SRS);
  assign cin = ~n_ACIN;
  assign daa = ~n_DAA;
  assign dsa = ~n_DSA & n_DAA;

  assign sum      = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, cin};
  assign hc       = ({1'b0, ai[3:0]} + {1'b0, bi[3:0]} + {4'b0, cin}) > 5'd15;
  assign overflow = (ai[7] == bi[7]) && (sum[7] != ai[7]);

  // Decimal flags feed the accumulator correction on the following SB_AC load.
  always_comb begin
    dc3_sum = 1'b0;
    dc7_sum = 1'b0;
    if (daa) begin
      dc3_sum = hc | (sum[3:0] > BCD_LIMIT);
      dc7_sum = sum[8] | (sum[7:4] > BCD_LIMIT) | ((sum[7:4] == BCD_LIMIT) & dc3_sum);
    end else if (dsa) begin
      dc3_sum = ~hc;
      dc7_sum = ~sum[8];
    end
  end

  always_comb begin
    add_d = add_q;
    acr_d = 1'b0;
    avr_d = 1'b0;
    case (op)
      OP_SUM: begin
        add_d = sum[WIDTH-1:0];
        acr_d = daa ? dc7_sum : sum[8];
        avr_d = overflow;
      end
      OP_AND: add_d = ai & bi;
      OP_EOR: add_d = ai ^ bi;
      OP_OR:  add_d = ai | bi;
      OP_SR: begin
        add_d = {1'b0, ai[WIDTH-1:1]};
        acr_d = ai[0];
      end
      default: begin
        add_d = add_q;
        acr_d = acr_q;
        avr_d = avr_q;
      end
    endcase
  end

  bcd_adjust u_bcd_adjust (
    .data   (SB_in),
    .dc3    (dc3_q),
    .dc7    (dc7_q),
    .mode   (mode_q),
    .result (ac_load)
  );

  always_ff @(posedge PHI0) begin
    if (!n_RES) begin
      ai     <= '0;
      bi     <= '0;
      add_q  <= '0;
      ac_q   <= '0;
      acr_q  <= 1'b0;
      avr_q  <= 1'b0;
      dc3_q  <= 1'b0;
      dc7_q  <= 1'b0;
      mode_q <= BCD_NONE;
    end else begin
      if (SB_ADD || Z_ADD)
        ai <= (SB_ADD ? SB_in : '1) & (Z_ADD ? '0 : '1);
      if (DB_ADD || NDB_ADD || ADL_ADD)
        bi <= (DB_ADD ? DB_in : '1) & (NDB_ADD ? ~DB_in : '1) & (ADL_ADD ? ADL_in : '1);
      if (op != OP_NONE) begin
        add_q <= add_d;
        acr_q <= acr_d;
        avr_q <= avr_d;
      end
      if (SB_AC) begin
        ac_q  <= ac_load;
        dc3_q <= 1'b0;
        dc7_q <= 1'b0;
      end
      // A sum on the same edge as a load owns the freshly computed flags.
      if (op == OP_SUM) begin
        dc3_q  <= dc3_sum;
        dc7_q  <= dc7_sum;
        mode_q <= daa ? BCD_ADD : (dsa ? BCD_SUB : BCD_NONE);
      end
    end
  end

  logic [WIDTH-1:0] add_sb, ac_sb;

  assign add_sb = {ADD_SB7, {(WIDTH-1){ADD_SB06}}};
  assign ac_sb  = {WIDTH{AC_SB}};

  // Where ADD and AC both drive a bit the bus resolves to their wired-AND.
  assign SB_out  = (add_q | ~add_sb) & (ac_q | (add_sb & ~ac_sb));
  assign SB_oe   = (add_sb | ac_sb) & {WIDTH{n_RES}};
  assign ADL_out = add_q;
  assign ADL_oe  = ADD_ADL & n_RES;
  assign DB_out  = ac_q;
  assign DB_oe   = AC_DB & n_RES;

  assign ADD    = add_q;
  assign AC     = ac_q;
  assign ACR    = acr_q;
  assign n_COUT = ~acr_q;
  assign AVR    = avr_q;

endmodule

// File: tb/tb_alu_datapath.sv
// tb/tb_alu_datapath.sv - self-checking bench for alu_datapath with a behavioural model
module tb_alu_datapath;

  logic       PHI0 = 1'b0;
  logic       n_RES;
  logic [7:0] SB_in, DB_in, ADL_in;
  logic       SB_ADD, Z_ADD, DB_ADD, NDB_ADD, ADL_ADD;
  logic       SUMS, ANDS, EORS, ORS, SRS;
  logic       n_ACIN, n_DAA, n_DSA;
  logic       ADD_SB06, ADD_SB7, ADD_ADL, SB_AC, AC_SB, AC_DB;
  logic [7:0] SB_out, SB_oe, ADL_out, DB_out, ADD, AC;
  logic       ADL_oe, DB_oe, n_COUT, ACR, AVR;

  int checks = 0;
  int errors = 0;

  // Model state: plain integers, decimal mode 0=none 1=add 2=sub.
  int m_ai, m_bi, m_add, m_ac, m_acr, m_avr, m_dc3, m_dc7, m_mode;

  always #5 PHI0 = ~PHI0;

  alu_datapath dut (
    .PHI0(PHI0), .n_RES(n_RES), .SB_in(SB_in), .DB_in(DB_in), .ADL_in(ADL_in),
    .SB_ADD(SB_ADD), .Z_ADD(Z_ADD), .DB_ADD(DB_ADD), .NDB_ADD(NDB_ADD), .ADL_ADD(ADL_ADD),
    .SUMS(SUMS), .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS),
    .n_ACIN(n_ACIN), .n_DAA(n_DAA), .n_DSA(n_DSA),
    .ADD_SB06(ADD_SB06), .ADD_SB7(ADD_SB7), .ADD_ADL(ADD_ADL),
    .SB_AC(SB_AC), .AC_SB(AC_SB), .AC_DB(AC_DB),
    .SB_out(SB_out), .SB_oe(SB_oe), .ADL_out(ADL_out), .ADL_oe(ADL_oe),
    .DB_out(DB_out), .DB_oe(DB_oe), .ADD(ADD), .AC(AC),
    .n_COUT(n_COUT), .ACR(ACR), .AVR(AVR)
  );

  task automatic clear_strobes();
    n_RES = 1; SB_ADD = 0; Z_ADD = 0; DB_ADD = 0; NDB_ADD = 0; ADL_ADD = 0;
    SUMS = 0; ANDS = 0; EORS = 0; ORS = 0; SRS = 0;
    n_ACIN = 1; n_DAA = 1; n_DSA = 1;
    ADD_SB06 = 0; ADD_SB7 = 0; ADD_ADL = 0; SB_AC = 0; AC_SB = 0; AC_DB = 0;
  endtask

  function automatic int bcd_fix(int v, int lo_adj, int hi_adj, int mode);
    int lo, hi;
    lo = v % 16;
    hi = v / 16;
    if (mode == 1) begin lo = (lo + lo_adj) % 16; hi = (hi + hi_adj) % 16; end
    if (mode == 2) begin lo = (lo - lo_adj + 16) % 16; hi = (hi - hi_adj + 16) % 16; end
    return hi * 16 + lo;
  endfunction

  task automatic model_step();
    int s, lo, r, c, hc, d3, d7, mask_sb, mask_z, b;
    if (!n_RES) begin
      m_ai = 0; m_bi = 0; m_add = 0; m_ac = 0; m_acr = 0; m_avr = 0;
      m_dc3 = 0; m_dc7 = 0; m_mode = 0;
      return;
    end
    if (SB_AC) begin
      m_ac = bcd_fix(int'(SB_in), m_dc3 ? 6 : 0, m_dc7 ? 6 : 0, m_mode);
      m_dc3 = 0; m_dc7 = 0;
    end
    if (SUMS) begin
      s  = m_ai + m_bi + (n_ACIN ? 0 : 1);
      lo = (m_ai % 16) + (m_bi % 16) + (n_ACIN ? 0 : 1);
      hc = (lo > 15) ? 1 : 0;
      r  = s % 256;
      c  = (s > 255) ? 1 : 0;
      m_add = r;
      m_avr = (((m_ai >= 128) == (m_bi >= 128)) && ((r >= 128) != (m_ai >= 128))) ? 1 : 0;
      if (!n_DAA) begin
        d3 = (hc || (r % 16 > 9)) ? 1 : 0;
        d7 = (c || (r / 16 > 9) || (r / 16 == 9 && d3 == 1)) ? 1 : 0;
        m_acr = d7; m_mode = 1;
      end else if (!n_DSA) begin
        d3 = 1 - hc; d7 = 1 - c; m_acr = c; m_mode = 2;
      end else begin
        d3 = 0; d7 = 0; m_acr = c; m_mode = 0;
      end
      m_dc3 = d3; m_dc7 = d7;
    end else if (ANDS) begin m_add = m_ai & m_bi; m_acr = 0; m_avr = 0;
    end else if (EORS) begin m_add = m_ai ^ m_bi; m_acr = 0; m_avr = 0;
    end else if (ORS)  begin m_add = m_ai | m_bi; m_acr = 0; m_avr = 0;
    end else if (SRS)  begin m_add = m_ai / 2; m_acr = m_ai % 2; m_avr = 0;
    end
    if (SB_ADD || Z_ADD) begin
      mask_sb = SB_ADD ? int'(SB_in) : 255;
      mask_z  = Z_ADD ? 0 : 255;
      m_ai = mask_sb & mask_z;
    end
    if (DB_ADD || NDB_ADD || ADL_ADD) begin
      b = 255;
      if (DB_ADD)  b = b & int'(DB_in);
      if (NDB_ADD) b = b & (255 - int'(DB_in));
      if (ADL_ADD) b = b & int'(ADL_in);
      m_bi = b;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge PHI0);
    #1;
  endtask

  task automatic test_reset();
    clear_strobes();
    n_RES = 0;
    {SB_ADD, Z_ADD, DB_ADD, NDB_ADD, ADL_ADD, SUMS, ANDS, EORS, ORS, SRS} = '1;
    {ADD_SB06, ADD_SB7, ADD_ADL, SB_AC, AC_SB, AC_DB} = '1;
    SB_in = 8'h5A; DB_in = 8'hA5; ADL_in = 8'h3C;
    cycle();
    checks++; if (ADD !== 8'h00) begin errors++; $display("FAIL reset_add got=%h exp=00", ADD); end
    checks++; if (AC !== 8'h00) begin errors++; $display("FAIL reset_ac got=%h exp=00", AC); end
    checks++; if ({n_COUT, ACR, AVR} !== 3'b100) begin errors++; $display("FAIL reset_flags got=%b exp=100", {n_COUT, ACR, AVR}); end
    checks++; if ({SB_oe, ADL_oe, DB_oe} !== 10'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", {SB_oe, ADL_oe, DB_oe}); end
    clear_strobes();
  endtask

  task automatic test_binary_add();
    clear_strobes(); SB_in = 8'h50; DB_in = 8'h50; SB_ADD = 1; DB_ADD = 1;
    cycle();
    clear_strobes(); SUMS = 1; n_ACIN = 1;
    cycle();
    checks++; if (ADD !== 8'hA0) begin errors++; $display("FAIL add_result got=%h exp=a0", ADD); end
    checks++; if ({ACR, AVR, n_COUT} !== 3'b011) begin errors++; $display("FAIL add_flags got=%b exp=011", {ACR, AVR, n_COUT}); end
  endtask

  task automatic test_subtract();
    clear_strobes(); SB_in = 8'h10; DB_in = 8'h01; SB_ADD = 1; NDB_ADD = 1;
    cycle();
    clear_strobes(); SUMS = 1; n_ACIN = 0;
    cycle();
    checks++; if (ADD !== 8'h0F) begin errors++; $display("FAIL sub_result got=%h exp=0f", ADD); end
    checks++; if ({ACR, AVR, n_COUT} !== 3'b100) begin errors++; $display("FAIL sub_flags got=%b exp=100", {ACR, AVR, n_COUT}); end
  endtask

  task automatic test_decimal_add();
    clear_strobes(); SB_in = 8'h19; DB_in = 8'h28; SB_ADD = 1; DB_ADD = 1;
    cycle();
    clear_strobes(); SUMS = 1; n_DAA = 0; n_ACIN = 1;
    cycle();
    checks++; if (ADD !== 8'h41) begin errors++; $display("FAIL daa_result got=%h exp=41", ADD); end
    checks++; if ({ACR, n_COUT} !== 2'b01) begin errors++; $display("FAIL daa_carry got=%b exp=01", {ACR, n_COUT}); end
    clear_strobes(); SB_AC = 1; SB_in = 8'h41;
    cycle();
    checks++; if (AC !== 8'h47) begin errors++; $display("FAIL daa_ac got=%h exp=47", AC); end
    clear_strobes(); AC_DB = 1;
    #1;
    checks++; if ({DB_oe, DB_out} !== 9'h147) begin errors++; $display("FAIL db_drive got=%h exp=147", {DB_oe, DB_out}); end
  endtask

  task automatic test_shift_hold();
    clear_strobes(); SB_in = 8'h81; SB_ADD = 1;
    cycle();
    clear_strobes(); SRS = 1;
    cycle();
    checks++; if (ADD !== 8'h40) begin errors++; $display("FAIL sr_result got=%h exp=40", ADD); end
    checks++; if ({ACR, n_COUT} !== 2'b10) begin errors++; $display("FAIL sr_carry got=%b exp=10", {ACR, n_COUT}); end
    clear_strobes();
    cycle();
    checks++; if ({ADD, ACR} !== 9'h081) begin errors++; $display("FAIL hold_add got=%h exp=081", {ADD, ACR}); end
    clear_strobes(); SRS = 1;
    cycle();
    checks++; if ({ADD, ACR} !== 9'h081) begin errors++; $display("FAIL hold_ai got=%h exp=081", {ADD, ACR}); end
    clear_strobes(); ADD_SB7 = 1; AC_SB = 1; ADD_ADL = 1;
    #1;
    checks++; if ({SB_oe, SB_out} !== 16'hFF47) begin errors++; $display("FAIL sb_wired_and got=%h exp=ff47", {SB_oe, SB_out}); end
    checks++; if ({ADL_oe, ADL_out} !== 9'h140) begin errors++; $display("FAIL adl_drive got=%h exp=140", {ADL_oe, ADL_out}); end
  endtask

  task automatic test_reset_mid_op();
    clear_strobes(); SB_in = 8'hFF; ADL_in = 8'h01; SB_ADD = 1; ADL_ADD = 1;
    cycle();
    clear_strobes(); SUMS = 1; n_ACIN = 1; n_RES = 0;
    cycle();
    checks++; if ({ADD, ACR, n_COUT} !== 10'h001) begin errors++; $display("FAIL mid_reset got=%h exp=001", {ADD, ACR, n_COUT}); end
    clear_strobes();
  endtask

  task automatic test_random();
    logic [7:0] e_sb_out, e_sb_oe;
    logic       add_en;
    for (int i = 0; i < 400; i++) begin
      clear_strobes();
      n_RES = ($urandom_range(0, 39) != 0);
      SB_in = 8'($urandom); DB_in = 8'($urandom); ADL_in = 8'($urandom);
      SB_ADD = ($urandom_range(0, 2) == 0); Z_ADD = ($urandom_range(0, 7) == 0);
      DB_ADD = ($urandom_range(0, 2) == 0); NDB_ADD = ($urandom_range(0, 5) == 0);
      ADL_ADD = ($urandom_range(0, 5) == 0);
      SUMS = ($urandom_range(0, 2) == 0); ANDS = ($urandom_range(0, 4) == 0);
      EORS = ($urandom_range(0, 4) == 0); ORS = ($urandom_range(0, 4) == 0);
      SRS = ($urandom_range(0, 4) == 0);
      n_ACIN = 1'($urandom); n_DAA = ($urandom_range(0, 2) != 0); n_DSA = ($urandom_range(0, 2) != 0);
      SB_AC = SUMS ? 1'b0 : ($urandom_range(0, 1) == 0);
      ADD_SB06 = 1'($urandom); ADD_SB7 = 1'($urandom); AC_SB = 1'($urandom);
      ADD_ADL = 1'($urandom); AC_DB = 1'($urandom);
      #1;
      for (int k = 0; k < 8; k++) begin
        add_en = (k == 7) ? ADD_SB7 : ADD_SB06;
        if (add_en && AC_SB) e_sb_out[k] = m_add[k] & m_ac[k];
        else if (add_en)     e_sb_out[k] = m_add[k];
        else                 e_sb_out[k] = m_ac[k];
        e_sb_oe[k] = n_RES & (add_en | AC_SB);
      end
      checks++; if ((SB_oe !== e_sb_oe) || ((SB_out & e_sb_oe) !== (e_sb_out & e_sb_oe)))
        begin errors++; $display("FAIL rnd_sb i=%0d got=%h/%h exp=%h/%h", i, SB_oe, SB_out, e_sb_oe, e_sb_out); end
      checks++; if ({ADL_oe, ADL_out, DB_oe, DB_out} !== {n_RES & ADD_ADL, 8'(m_add), n_RES & AC_DB, 8'(m_ac)})
        begin errors++; $display("FAIL rnd_drive i=%0d got=%b%h%b%h", i, ADL_oe, ADL_out, DB_oe, DB_out); end
      cycle();
      checks++; if ({ADD, AC} !== {8'(m_add), 8'(m_ac)})
        begin errors++; $display("FAIL rnd_regs i=%0d got=%h %h exp=%h %h", i, ADD, AC, 8'(m_add), 8'(m_ac)); end
      checks++; if ({ACR, AVR, n_COUT} !== {1'(m_acr), 1'(m_avr), ~1'(m_acr)})
        begin errors++; $display("FAIL rnd_flags i=%0d got=%b exp=%b%b%b", i, {ACR, AVR, n_COUT}, 1'(m_acr), 1'(m_avr), ~1'(m_acr)); end
    end
  endtask

  initial begin
    clear_strobes();
    SB_in = 0; DB_in = 0; ADL_in = 0;
    m_ai = 0; m_bi = 0; m_add = 0; m_ac = 0; m_acr = 0; m_avr = 0;
    m_dc3 = 0; m_dc7 = 0; m_mode = 0;
    test_reset();
    test_binary_add();
    test_subtract();
    test_decimal_add();
    test_shift_hold();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
Name: alu_datapath

Overview:
- Single-clock 6502 ALU datapath; sits directly downstream of ALU control and consumes its operand-select, op-select, carry-in, BCD and output-enable strobes.
- Holds the AI/BI input latches, the ADD result register, the accumulator (AC) and the decimal-correction flags.
- Returns n_COUT to ALU control as feedback.
- One PHI0 rising edge equals one full CPU cycle; phase detail is folded into registered timing.

Parameters:
- WIDTH, 8, data path width; only 8 is supported.

Ports:
- PHI0  in  1  system clock; all state updates on the rising edge.
- n_RES  in  1  synchronous active-low reset.
- SB_in  in  8  resolved SB bus value.
- DB_in  in  8  resolved DB bus value.
- ADL_in  in  8  resolved ADL bus value.
- SB_ADD, Z_ADD  in  1  AI source selects.
- DB_ADD, NDB_ADD, ADL_ADD  in  1  BI source selects.
- SUMS, ANDS, EORS, ORS, SRS  in  1  operation selects.
- n_ACIN  in  1  carry in, active low.
- n_DAA  in  1  decimal add adjust, active low.
- n_DSA  in  1  decimal subtract adjust, active low.
- ADD_SB06, ADD_SB7, ADD_ADL  in  1  ADD output enables.
- SB_AC, AC_SB, AC_DB  in  1  accumulator load and drive strobes.
- SB_out  out  8  ADD or AC drive value for SB.
- SB_oe  out  8  per-bit SB drive enable.
- ADL_out  out  8  ADD drive value for ADL.
- ADL_oe  out  1  ADL drive enable.
- DB_out  out  8  AC drive value for DB.
- DB_oe  out  1  DB drive enable.
- ADD  out  8  ADD register.
- AC  out  8  accumulator.
- n_COUT  out  1  registered carry out, active low.
- ACR  out  1  registered carry flag.
- AVR  out  1  registered overflow flag.

Behaviour:
- Reset (n_RES=0 at an edge):
  - AI=BI=ADD=AC=0; ACR=AVR=0; n_COUT=1; DC3=DC7=0; all output enables 0.
  - Reset wins over every strobe on the same edge, including mid-operation.
- Operand latches (edge k):
  - AI <= (SB_ADD?SB_in:FF) & (Z_ADD?00:FF).
  - BI <= (DB_ADD?DB_in:FF) & (NDB_ADD?~DB_in:FF) & (ADL_ADD?ADL_in:FF).
  - Multiple selects combine by wired-AND.
  - If no select is active for a latch, that latch holds its value.
- Operation (combinational on the latched AI/BI, registered at edge k+1):
  - Latency from operand select to ADD valid is one cycle.
  - Priority: SUMS > ANDS > EORS > ORS > SRS. If no op is selected, ADD, ACR and AVR hold.
  - SUMS: 9-bit sum = AI + BI + ~n_ACIN. ADD <= sum[7:0]. ACR <= sum[8]. AVR <= (AI7==BI7)&&(sum7!=AI7).
  - ANDS / EORS / ORS: ADD <= AI&BI, AI^BI or AI|BI respectively. ACR=0, AVR=0.
  - SRS: ADD <= {0, AI[7:1]}. ACR <= AI[0]. AVR=0.
  - n_COUT = ~ACR at all times, registered together with ACR.
- Decimal mode, with SUMS and n_DAA=0:
  - Low-nibble carry HC = (AI[3:0]+BI[3:0]+cin) > 15.
  - DC3 <= HC | (low result > 9).
  - DC7 <= carry | (high result > 9) | (high result == 9 & DC3).
  - ACR and n_COUT report the decimal carry, ACR = DC7.
- Decimal mode, with SUMS and n_DSA=0:
  - DC3 <= ~HC; DC7 <= ~carry.
  - ACR reports the binary carry.
- Decimal flags outside decimal mode:
  - If neither n_DAA nor n_DSA is asserted while SUMS is active, DC3=DC7=0.
  - When SUMS is not active, DC3 and DC7 hold.
  - n_DAA=0 and n_DSA=0 together: DAA takes precedence.
- Accumulator load (edge, SB_AC=1):
  - With DAA mode latched: AC <= SB_in corrected nibble-wise, adding 6 to the low nibble if DC3 and 6 to the high nibble if DC7, mod 16 per nibble, with no inter-nibble carry.
  - With DSA mode latched: subtract 6 per nibble instead.
  - Otherwise AC <= SB_in.
  - After the load, DC3 and DC7 clear.
- Output drive (combinational from registers):
  - SB_oe[6:0] = ADD_SB06 | AC_SB.
  - SB_oe[7] = ADD_SB7 | AC_SB.
  - SB_out bits take ADD where ADD_SB* is active, otherwise AC.
  - If both ADD_SB* and AC_SB are active on a bit, SB_out = ADD & AC (wired-AND).
  - ADL_oe = ADD_ADL, ADL_out = ADD.
  - DB_oe = AC_DB, DB_out = AC.
- Simultaneous SB_AC and an ALU operation on the same edge: AC loads SB_in from the current cycle, and ADD updates independently.

Decomposition:
- Shared package core6502_alu_pkg holds:
  - alu_op_t enum {OP_NONE, OP_SUM, OP_AND, OP_EOR, OP_OR, OP_SR};
  - BCD_LIMIT = 9;
  - BCD_ADJ = 6.
- One sub-module, bcd_adjust: a combinational nibble correction taking SB_in, DC3, DC7 and the add/sub mode, producing the corrected byte.

Test Plan:
- Reset with all strobes high -> ADD=00, AC=00, n_COUT=1, ACR=0, AVR=0, all *_oe=0. Then release reset.
- Binary add: SB=0x50 via SB_ADD, DB=0x50 via DB_ADD, SUMS, n_ACIN=1 -> next cycle ADD=0xA0, ACR=0, AVR=1, n_COUT=1.
- Subtract: SB=0x10, DB=0x01 via NDB_ADD, SUMS, n_ACIN=0 -> ADD=0x0F, ACR=1, AVR=0.
- Decimal add: SB=0x19, DB=0x28, SUMS, n_DAA=0, n_ACIN=1 -> ADD=0x41, DC3=1, DC7=0. Then SB_AC with SB_in=0x41 -> AC=0x47.
- Shift and hold: AI=0x81 via SB_ADD, SRS -> ADD=0x40, ACR=1. Next cycle with no op and no selects -> ADD stays 0x40 and AI stays 0x81.
- Reset mid-operation: SUMS in flight with AI=0xFF, BI=0x01 and n_RES=0 on the completing edge -> ADD=00, ACR=0, n_COUT=1.
